// File: rtl/mem_if_pkg.sv
// Shared definitions for the CPU data-memory port: size encodings, responder states and the
// alignment rule used by both the responder and the CPU exception logic.
package mem_if_pkg;

  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_WORD = 2'b10;
  localparam logic [1:0] SIZE_RSVD = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_RESP
  } state_e;

  // 1 when an access of the given size may start at the given byte offset.
  function automatic logic addr_aligned(input logic [1:0] size_i, input logic [1:0] addr_lo_i);
    logic ok;
    ok = 1'b0;
    case (size_i)
      SIZE_BYTE: ok = 1'b1;
      SIZE_HALF: ok = ~addr_lo_i[0];
      SIZE_WORD: ok = (addr_lo_i == 2'b00);
      default:   ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/dmem_bram_bytewe.sv
// Word-wide RAM with per-byte write enables and a registered read port; no reset so it maps
// onto a block RAM.
module dmem_bram_bytewe #(
  parameter int unsigned ADDR_W = 10
) (
  input  logic              clk_i,
  input  logic [3:0]        we_i,
  input  logic              re_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [31:0]       wdata_i,
  output logic [31:0]       rdata_o
);

  logic [31:0] mem_q [2**ADDR_W];
  logic [31:0] rdata_q;

  always_ff @(posedge clk_i) begin
    for (int i = 0; i < 4; i++) begin
      if (we_i[i]) begin
        mem_q[addr_i][8*i +: 8] <= wdata_i[8*i +: 8];
      end
    end
    // Read register only moves on a read, so it holds the last loaded word.
    if (re_i) begin
      rdata_q <= mem_q[addr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/data_mem_responder.sv
// Memory-side responder for the CPU M-stage data port: accepts a request, waits WAIT_CYCLES,
// commits a byte-lane write or word read, and pulses rvalid (with err for illegal accesses).
module data_mem_responder
  import mem_if_pkg::*;
#(
  parameter int unsigned ADDR_W      = 10,
  parameter int unsigned WAIT_CYCLES = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        memen,
  input  logic        memwrite,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic [3:0]  sel,
  input  logic [1:0]  size,
  output logic [31:0] rdata,
  output logic        stall,
  output logic        rvalid,
  output logic        err
);

  localparam logic [3:0] CntLoad = (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);

  state_e            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [ADDR_W+1:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [3:0]        sel_q, sel_d;
  logic [1:0]        size_q, size_d;
  logic              we_q, we_d;
  logic              rd_vld_q, rd_vld_d;

  logic              in_idle;
  logic              accept;
  logic              commit;
  logic              req_ok;
  logic              req_we;
  logic [ADDR_W+1:0] req_addr;
  logic [31:0]       req_wdata;
  logic [3:0]        req_sel;
  logic [1:0]        req_size;
  logic [3:0]        ram_we;
  logic              ram_re;
  logic [31:0]       ram_rdata;
  logic              unused_addr;

  assign unused_addr = ^addr[31:ADDR_W+2];

  assign in_idle = (state_q == ST_IDLE);
  assign accept  = in_idle & memen;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      ST_IDLE: begin
        if (memen) begin
          if (WAIT_CYCLES == 0) begin
            state_d = ST_RESP;
          end else begin
            state_d = ST_WAIT;
            cnt_d   = CntLoad;
          end
        end
      end
      ST_WAIT: begin
        if (cnt_q == 4'd0) begin
          state_d = ST_RESP;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    addr_d  = addr_q;
    wdata_d = wdata_q;
    sel_d   = sel_q;
    size_d  = size_q;
    we_d    = we_q;
    if (accept) begin
      addr_d  = addr[ADDR_W+1:0];
      wdata_d = wdata;
      sel_d   = sel;
      size_d  = size;
      we_d    = memwrite;
    end
  end

  // With no wait states the accept edge is also the commit edge, so commit from the live port.
  always_comb begin
    req_addr  = in_idle ? addr[ADDR_W+1:0] : addr_q;
    req_wdata = in_idle ? wdata : wdata_q;
    req_sel   = in_idle ? sel : sel_q;
    req_size  = in_idle ? size : size_q;
    req_we    = in_idle ? memwrite : we_q;
  end

  assign commit   = (state_d == ST_RESP) && (state_q != ST_RESP);
  assign req_ok   = addr_aligned(req_size, req_addr[1:0]);
  assign ram_we   = (commit && req_we && req_ok) ? req_sel : 4'b0000;
  assign ram_re   = commit && !req_we && req_ok;
  assign rd_vld_d = rd_vld_q | ram_re;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      cnt_q    <= 4'd0;
      addr_q   <= '0;
      wdata_q  <= '0;
      sel_q    <= '0;
      size_q   <= '0;
      we_q     <= 1'b0;
      rd_vld_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      sel_q    <= sel_d;
      size_q   <= size_d;
      we_q     <= we_d;
      rd_vld_q <= rd_vld_d;
    end
  end

  dmem_bram_bytewe #(
    .ADDR_W(ADDR_W)
  ) u_ram (
    .clk_i  (clk),
    .we_i   (ram_we),
    .re_i   (ram_re),
    .addr_i (req_addr[ADDR_W+1:2]),
    .wdata_i(req_wdata),
    .rdata_o(ram_rdata)
  );

  // The RAM read register has no reset; mask it until a load has committed since reset.
  assign rdata  = rd_vld_q ? ram_rdata : 32'h0;
  assign stall  = ~rst & (accept | (state_q == ST_WAIT));
  assign rvalid = (state_q == ST_RESP);
  assign err    = rvalid & ~addr_aligned(size_q, addr_q[1:0]);

endmodule
